// File: rtl/lcd_write_arbiter.sv
// Arbitrates the LCD write engine between init, picture and character drawers with a stall watchdog.
// Define LCD_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module lcd_write_arbiter #(
  parameter int N_REQ       = 3,
  parameter int DATA_W      = 9,
  parameter int CNT_W       = 18,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          req_wr_en,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          req_wr_done,
  output logic                      lcd_wr_en,
  output logic [DATA_W-1:0]         lcd_wr_data,
  input  logic                      lcd_wr_done,
  output logic                      busy,
  output logic [CNT_W-1:0]          word_cnt,
  output logic                      timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RELEASE} state_t;

  state_t             state_reg, state_next;
  logic [N_REQ-1:0]   gnt_reg, gnt_next;
  logic [CNT_W-1:0]   word_cnt_reg, word_cnt_next;
  logic [WD_W-1:0]    wd_reg, wd_next;
  logic [N_REQ-1:0]   win_onehot;
  logic               win_found;
  logic               in_busy;
  logic               hold;
  logic               stall;
  logic               timeout_hit;
  logic [DATA_W-1:0]  sel_data;
  logic [DATA_W-1:0]  data_masked [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_data_mask
      assign data_masked[gi] = gnt_reg[gi] ? req_data[gi*DATA_W +: DATA_W] : '0;
    end
  endgenerate

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_data = sel_data | data_masked[i];
    end
  end

  // The engine sees the holder combinationally from the registered grant.
  assign in_busy     = (state_reg == ST_BUSY);
  assign lcd_wr_en   = in_busy & |(gnt_reg & req_wr_en);
  assign lcd_wr_data = in_busy ? sel_data : '0;
  assign req_wr_done = (in_busy && lcd_wr_done) ? gnt_reg : '0;
  assign gnt         = gnt_reg;
  assign busy        = (state_reg != ST_IDLE);
  assign word_cnt    = word_cnt_reg;

  // A holder keeps the grant while either its request or an outstanding write is up.
  assign hold        = |(gnt_reg & (req | req_wr_en));
  assign stall       = !lcd_wr_en && !lcd_wr_done;
  assign timeout_hit = in_busy && stall && (wd_reg == WD_LAST);
  assign timeout_err = timeout_hit;

`ifdef LCD_ARB_RR_EN
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0] ptr_reg;
  logic [PTR_W-1:0] rr_idx;
  logic [PTR_W-1:0] win_idx;

  // Scan starts just after the last granted index and wraps.
  always_comb begin
    win_onehot = '0;
    win_found  = 1'b0;
    win_idx    = ptr_reg;
    rr_idx     = ptr_reg;
    for (int k = 0; k < N_REQ; k++) begin
      if (rr_idx == PTR_W'(N_REQ - 1)) begin
        rr_idx = '0;
      end else begin
        rr_idx = rr_idx + 1'b1;
      end
      if (!win_found && req[rr_idx]) begin
        win_onehot[rr_idx] = 1'b1;
        win_idx            = rr_idx;
        win_found          = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ptr_reg <= PTR_W'(N_REQ - 1);
    end else if (state_reg == ST_IDLE && win_found) begin
      ptr_reg <= win_idx;
    end
  end
`else
  always_comb begin
    win_onehot = '0;
    win_found  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_found && req[i]) begin
        win_onehot[i] = 1'b1;
        win_found     = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    state_next    = state_reg;
    gnt_next      = gnt_reg;
    word_cnt_next = word_cnt_reg;
    wd_next       = '0;
    case (state_reg)
      ST_IDLE: begin
        if (win_found) begin
          gnt_next      = win_onehot;
          word_cnt_next = '0;
          state_next    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (lcd_wr_done && (word_cnt_reg != '1)) begin
          word_cnt_next = word_cnt_reg + 1'b1;
        end
        if (stall) begin
          wd_next = wd_reg + 1'b1;
        end
        if (!hold || timeout_hit) begin
          gnt_next   = '0;
          state_next = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_next = ST_IDLE;
      end
      default: begin
        gnt_next   = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg    <= ST_IDLE;
      gnt_reg      <= '0;
      word_cnt_reg <= '0;
      wd_reg       <= '0;
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      word_cnt_reg <= word_cnt_next;
      wd_reg       <= wd_next;
    end
  end

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Self-checking bench for lcd_write_arbiter: per-cycle vector table plus multi-cycle session sequences.
module tb_lcd_write_arbiter;

  localparam int N  = 3;
  localparam int DW = 9;
  localparam int CW = 18;
  localparam int TO = 4096;

  logic            sys_clk = 1'b0;
  logic            sys_rst;
  logic [N-1:0]    req;
  logic [N-1:0]    req_wr_en;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    gnt;
  logic [N-1:0]    req_wr_done;
  logic            lcd_wr_en;
  logic [DW-1:0]   lcd_wr_data;
  logic            lcd_wr_done;
  logic            busy;
  logic [CW-1:0]   word_cnt;
  logic            timeout_err;

  lcd_write_arbiter #(.N_REQ(N), .DATA_W(DW), .CNT_W(CW), .TIMEOUT_CYC(TO)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .req         (req),
    .req_wr_en   (req_wr_en),
    .req_data    (req_data),
    .gnt         (gnt),
    .req_wr_done (req_wr_done),
    .lcd_wr_en   (lcd_wr_en),
    .lcd_wr_data (lcd_wr_data),
    .lcd_wr_done (lcd_wr_done),
    .busy        (busy),
    .word_cnt    (word_cnt),
    .timeout_err (timeout_err)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  en;
    logic        done;
    logic [2:0]  gnt;
    logic        lcd_en;
    logic [8:0]  data;
    logic [2:0]  rwd;
    logic [17:0] cnt;
    logic        busy;
  } vec_t;

  vec_t vecs [20];
  int n_chk  = 0;
  int n_fail = 0;

  function automatic vec_t mk(input logic [2:0] r, input logic [2:0] e, input logic d,
                              input logic [2:0] g, input logic le, input logic [8:0] dat,
                              input logic [2:0] rwd, input logic [17:0] c, input logic b);
    vec_t v;
    v.req = r; v.en = e; v.done = d; v.gnt = g; v.lcd_en = le;
    v.data = dat; v.rwd = rwd; v.cnt = c; v.busy = b;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs are driven 2 time units after the rising edge; outputs are read 1 unit later.
  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wait_gnt(input int limit, output int cycles);
    cycles = 0;
    settle();
    while (gnt == '0 && cycles < limit) begin
      tick();
      settle();
      cycles++;
    end
  endtask

  // Two write handshakes from the granted requester, then its request is dropped.
  task automatic two_words(input int idx);
    req_wr_en[idx] = 1'b1;
    tick();
    lcd_wr_done = 1'b1;
    settle();
    chk("sess_rwd", 32'(req_wr_done), 32'(1 << idx));
    tick();
    lcd_wr_done = 1'b0;
    req_wr_en[idx] = 1'b0;
    tick();
    req_wr_en[idx] = 1'b1;
    tick();
    lcd_wr_done = 1'b1;
    tick();
    lcd_wr_done = 1'b0;
    req_wr_en[idx] = 1'b0;
    settle();
    chk("sess_cnt", 32'(word_cnt), 32'd2);
    req[idx] = 1'b0;
  endtask

  initial begin
    int cyc;
    int gap;
    logic [2:0] exp_order [3];

    sys_rst     = 1'b1;
    req         = '0;
    req_wr_en   = '0;
    lcd_wr_done = 1'b0;
    req_data    = {9'h13C, 9'h0A5, 9'h101};

    //               req     en      d     gnt     le    data    rwd     cnt busy
    vecs[0]  = mk(3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 9'h000, 3'b000, 18'd0, 1'b0);
    vecs[1]  = mk(3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 9'h000, 3'b000, 18'd0, 1'b0);
    vecs[2]  = mk(3'b110, 3'b000, 1'b0, 3'b000, 1'b0, 9'h000, 3'b000, 18'd0, 1'b0);
    vecs[3]  = mk(3'b110, 3'b010, 1'b0, 3'b010, 1'b1, 9'h0A5, 3'b000, 18'd0, 1'b1);
    vecs[4]  = mk(3'b110, 3'b010, 1'b1, 3'b010, 1'b1, 9'h0A5, 3'b010, 18'd0, 1'b1);
    vecs[5]  = mk(3'b110, 3'b000, 1'b0, 3'b010, 1'b0, 9'h0A5, 3'b000, 18'd1, 1'b1);
    vecs[6]  = mk(3'b110, 3'b010, 1'b0, 3'b010, 1'b1, 9'h0A5, 3'b000, 18'd1, 1'b1);
    vecs[7]  = mk(3'b110, 3'b010, 1'b1, 3'b010, 1'b1, 9'h0A5, 3'b010, 18'd1, 1'b1);
    vecs[8]  = mk(3'b110, 3'b000, 1'b0, 3'b010, 1'b0, 9'h0A5, 3'b000, 18'd2, 1'b1);
    vecs[9]  = mk(3'b110, 3'b010, 1'b1, 3'b010, 1'b1, 9'h0A5, 3'b010, 18'd2, 1'b1);
    vecs[10] = mk(3'b110, 3'b000, 1'b0, 3'b010, 1'b0, 9'h0A5, 3'b000, 18'd3, 1'b1);
    vecs[11] = mk(3'b110, 3'b010, 1'b1, 3'b010, 1'b1, 9'h0A5, 3'b010, 18'd3, 1'b1);
    vecs[12] = mk(3'b100, 3'b000, 1'b0, 3'b010, 1'b0, 9'h0A5, 3'b000, 18'd4, 1'b1);
    vecs[13] = mk(3'b100, 3'b000, 1'b0, 3'b000, 1'b0, 9'h000, 3'b000, 18'd4, 1'b1);
    vecs[14] = mk(3'b100, 3'b000, 1'b0, 3'b000, 1'b0, 9'h000, 3'b000, 18'd4, 1'b0);
    vecs[15] = mk(3'b100, 3'b100, 1'b1, 3'b100, 1'b1, 9'h13C, 3'b100, 18'd0, 1'b1);
    vecs[16] = mk(3'b000, 3'b000, 1'b0, 3'b100, 1'b0, 9'h13C, 3'b000, 18'd1, 1'b1);
    vecs[17] = mk(3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 9'h000, 3'b000, 18'd1, 1'b1);
    vecs[18] = mk(3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 9'h000, 3'b000, 18'd1, 1'b0);
    vecs[19] = mk(3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 9'h000, 3'b000, 18'd1, 1'b0);

    #3;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_lcd_wr_en", 32'(lcd_wr_en), 32'd0);
    chk("rst_lcd_wr_data", 32'(lcd_wr_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    tick();

    for (int i = 0; i < 20; i++) begin
      req         = vecs[i].req;
      req_wr_en   = vecs[i].en;
      lcd_wr_done = vecs[i].done;
      settle();
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      chk($sformatf("v%0d_lcd_wr_en", i), 32'(lcd_wr_en), 32'(vecs[i].lcd_en));
      chk($sformatf("v%0d_lcd_wr_data", i), 32'(lcd_wr_data), 32'(vecs[i].data));
      chk($sformatf("v%0d_req_wr_done", i), 32'(req_wr_done), 32'(vecs[i].rwd));
      chk($sformatf("v%0d_word_cnt", i), 32'(word_cnt), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      $display("vector %0d: req=%b en=%b done=%b gnt=%b cnt=%0d", i, req, req_wr_en,
               lcd_wr_done, gnt, word_cnt);
      tick();
    end
    lcd_wr_done = 1'b0;
    req = '0;
    req_wr_en = '0;

    // All three requesting: sessions in index order with a two-cycle idle gap between them.
    exp_order[0] = 3'b001;
    exp_order[1] = 3'b010;
    exp_order[2] = 3'b100;
    req = 3'b111;
    wait_gnt(10, cyc);
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("order%0d_gnt", s), 32'(gnt), 32'(exp_order[s]));
      two_words(s);
      if (s < 2) begin
        gap = 0;
        tick();
        settle();
        while (gnt == '0 && gap < 20) begin
          chk("gap_lcd_wr_en", 32'(lcd_wr_en), 32'd0);
          gap++;
          tick();
          settle();
        end
        chk($sformatf("gap%0d_cycles", s), 32'(gap), 32'd2);
      end
      $display("session %0d: gnt order entry %b", s, exp_order[s]);
    end
    tick();
    tick();
    tick();
    settle();
    chk("order_done_busy", 32'(busy), 32'd0);

    // Requester 0 re-requests alongside 1 right after its session.
    req = 3'b001;
    wait_gnt(10, cyc);
    chk("rr_first_gnt", 32'(gnt), 32'b001);
    req = 3'b010;
    tick();
    req = 3'b011;
    tick();
    tick();
    settle();
`ifdef LCD_ARB_RR_EN
    chk("rr_next_gnt", 32'(gnt), 32'b010);
`else
    chk("prio_next_gnt", 32'(gnt), 32'b001);
`endif
    $display("arbitration after req=011: gnt=%b", gnt);
    req = 3'b000;
    tick();
    tick();
    tick();

    // Request dropped while a write is outstanding: the grant holds until wr_en falls.
    req = 3'b010;
    wait_gnt(10, cyc);
    chk("hold_gnt", 32'(gnt), 32'b010);
    req_wr_en = 3'b010;
    tick();
    req = 3'b000;
    for (int k = 0; k < 3; k++) begin
      tick();
      settle();
      chk($sformatf("hold%0d_gnt", k), 32'(gnt), 32'b010);
    end
    req_wr_en = 3'b000;
    tick();
    settle();
    chk("hold_release_gnt", 32'(gnt), 32'b000);
    chk("hold_release_busy", 32'(busy), 32'd1);
    tick();
    settle();
    chk("hold_idle_busy", 32'(busy), 32'd0);
    $display("hold-over session released");

    // Stalled holder: watchdog fires in the TO-th grant cycle, grant drops the next cycle.
    req = 3'b001;
    wait_gnt(10, cyc);
    chk("wd_gnt", 32'(gnt), 32'b001);
    cyc = 1;
    while (!timeout_err && cyc < TO + 20) begin
      tick();
      settle();
      cyc++;
    end
    chk("wd_cycles", 32'(cyc), 32'(TO));
    chk("wd_pulse", 32'(timeout_err), 32'd1);
    chk("wd_gnt_at_pulse", 32'(gnt), 32'b001);
    tick();
    settle();
    chk("wd_gnt_after", 32'(gnt), 32'b000);
    chk("wd_pulse_after", 32'(timeout_err), 32'd0);
    tick();
    tick();
    settle();
    chk("wd_regrant", 32'(gnt), 32'b001);
    $display("watchdog release after %0d grant cycles", cyc);
    req = 3'b000;
    tick();
    tick();
    tick();

    // Reset mid-session clears everything immediately; first request afterwards is granted in one cycle.
    req = 3'b010;
    req_wr_en = 3'b010;
    wait_gnt(10, cyc);
    chk("mid_lcd_wr_en", 32'(lcd_wr_en), 32'd1);
    sys_rst = 1'b1;
    settle();
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_lcd_wr_en", 32'(lcd_wr_en), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cnt", 32'(word_cnt), 32'd0);
    req = 3'b100;
    req_wr_en = 3'b000;
    sys_rst = 1'b0;
    tick();
    settle();
    chk("post_rst_gnt", 32'(gnt), 32'b100);
    $display("reset mid-session then gnt=%b", gnt);
    req = 3'b000;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "simulation time limit");
  end

endmodule
